edge_raster: RTL and testbench
==============================

EDGE_RASTER -- requirements
Module: edge_raster

Interface
REQ-001 Parameter BUF_DIM, default 64, meaning edge bitmap side length in pixels; BUF_DIM*BUF_DIM is the line_buffer width.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 n_rst  input  1  reset, asynchronous, active-low.
REQ-004 coordinates  input  48  triangle vertices, 8-bit unsigned each: {y2,x2,y1,x1,y0,x0}; x0=[7:0], y0=[15:8], x1=[23:16], y1=[31:24], x2=[39:32], y2=[47:40].
REQ-005 raster_start  input  1  request; sampled only in IDLE.
REQ-006 raster_busy  output  1  high in every state except IDLE.
REQ-007 raster_done  output  1  one-cycle pulse when the bitmap is complete.
REQ-008 raster_error  output  1  bounding box exceeds BUF_DIM; valid from done pulse until next accepted start.
REQ-009 line_buffer  output  4096  edge bitmap; row r = [r*64 +: 64]; bit c of row r = pixel (xmin+c, ymin+r).

Function
REQ-010 FSM states: IDLE, SETUP, LINE, DONE; IDLE->SETUP on raster_start; SETUP->LINE, or ->DONE if oversize; LINE->DONE after last pixel of edge 2; DONE->IDLE unconditionally.
REQ-011 SETUP: latch coordinates; xmin/ymin = minimum of the three x / three y; xmax/ymax likewise; clear line_buffer to 0; clear raster_error; load edge 0.
REQ-012 Oversize: (xmax-xmin)>63 or (ymax-ymin)>63 sets raster_error; no pixels are drawn; buffer stays all-zero.
REQ-013 Edge order: edge 0 = v0->v1, edge 1 = v1->v2, edge 2 = v2->v0; endpoints inclusive.
REQ-014 LINE: exactly one pixel set per cycle at (x-xmin, y-ymin); pixels already set remain 1 (OR semantics).
REQ-015 Bresenham, signed 10-bit arithmetic: dx=|xb-xa|, dy=-|yb-ya|, sx/sy=±1 toward the end point, err=dx+dy; per step e2=2*err; if e2>=dy then err+=dy, x+=sx; if e2<=dx then err+=dx, y+=sy.
REQ-016 Edge ends in the cycle its end point is written; the next edge loads in the following cycle with no bubble; edge pixel count = max(|dx|,|dy|)+1.
REQ-017 Latency: start sampled in cycle N -> raster_done high in cycle N+2+P (P = sum of the three edge pixel counts); oversize -> N+2.
REQ-018 line_buffer holds its value from DONE until the SETUP of the next accepted start.
REQ-019 raster_start while busy is ignored; no queuing.
REQ-020 Degenerate inputs (coincident vertices, collinear) are legal; zero-length edges write one pixel in one cycle.

Reset
REQ-021 n_rst low: state=IDLE; raster_busy=0, raster_done=0, raster_error=0, line_buffer=0, all counters/error terms=0, at any time including mid-LINE.
REQ-022 First start after reset release behaves identically to any other start.

Structure
REQ-023 The state enum and BUF_DIM belong in the shared package gpu_pkg.
REQ-024 One sub-module, line_stepper, holds x/y/err/sx/sy and performs one Bresenham step per cycle with load/step/last outputs; edge_raster owns FSM, bbox, and buffer.

Verification
REQ-025 Triangle (10,20),(20,20),(10,30): row 0 bits 0..10 set; column 0 rows 0..10 set; row k bit 10-k set for k=0..10; all other bits 0; raster_done at N+35.
REQ-026 All vertices (5,5): only row 0 bit 0 set; raster_done at N+5; raster_error=0.
REQ-027 Triangle (0,0),(100,0),(0,10): raster_error=1, line_buffer all-zero, raster_done at N+2.
REQ-028 Triangle (0,0),(63,63),(0,63): row 63 all 64 bits set, diagonal bit r of row r set, raster_error=0 (boundary size accepted).
REQ-029 n_rst asserted mid-LINE of the first case: outputs zero immediately; a new start after release reproduces REQ-025 exactly.
REQ-030 raster_start pulsed during LINE with different coordinates: ignored; result and timing equal to REQ-025.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared definitions for the GPU raster blocks: bitmap size, raster FSM states
// and small bounding-box helpers.
package gpu_pkg;

    localparam int unsigned BUF_DIM = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        LINE  = 2'd2,
        DONE  = 2'd3
    } raster_state_t;

    function automatic logic [7:0] min3(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c);
        logic [7:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic [7:0] max3(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c);
        logic [7:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

endpackage

// File: rtl/line_stepper.sv
// Bresenham line walker: load latches an edge, each step advances one pixel,
// last flags that the current pixel is the edge end point.
module line_stepper (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       load,
    input  logic       step,
    input  logic [7:0] xa,
    input  logic [7:0] ya,
    input  logic [7:0] xb,
    input  logic [7:0] yb,
    output logic [7:0] x,
    output logic [7:0] y,
    output logic       last
);

    logic signed [9:0]  x_q, y_q, err_q, dx_q, dy_q;
    logic signed [1:0]  sx_q, sy_q;
    logic        [7:0]  xb_q, yb_q;

    logic        [9:0]  adx, ady;
    logic signed [10:0] e2;
    logic signed [9:0]  x_n, y_n, err_n;

    always_comb begin
        adx = (xb >= xa) ? {2'b00, xb - xa} : {2'b00, xa - xb};
        ady = (yb >= ya) ? {2'b00, yb - ya} : {2'b00, ya - yb};
    end

    // Both error updates accumulate from the same e2, taken before either adjustment.
    always_comb begin
        e2    = {err_q, 1'b0};
        err_n = err_q;
        x_n   = x_q;
        y_n   = y_q;
        if (e2 >= dy_q) begin
            err_n = err_n + dy_q;
            x_n   = x_q + sx_q;
        end
        if (e2 <= dx_q) begin
            err_n = err_n + dx_q;
            y_n   = y_q + sy_q;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            x_q   <= '0;
            y_q   <= '0;
            err_q <= '0;
            dx_q  <= '0;
            dy_q  <= '0;
            sx_q  <= '0;
            sy_q  <= '0;
            xb_q  <= '0;
            yb_q  <= '0;
        end else if (load) begin
            x_q   <= $signed({2'b00, xa});
            y_q   <= $signed({2'b00, ya});
            dx_q  <= $signed(adx);
            dy_q  <= -$signed(ady);
            err_q <= $signed(adx) - $signed(ady);
            sx_q  <= (xb >= xa) ? 2'sb01 : 2'sb11;
            sy_q  <= (yb >= ya) ? 2'sb01 : 2'sb11;
            xb_q  <= xb;
            yb_q  <= yb;
        end else if (step) begin
            x_q   <= x_n;
            y_q   <= y_n;
            err_q <= err_n;
        end
    end

    assign x    = x_q[7:0];
    assign y    = y_q[7:0];
    assign last = (x_q[7:0] == xb_q) && (y_q[7:0] == yb_q);

endmodule

// File: rtl/edge_raster.sv
// Triangle edge rasteriser: draws the three edges of a triangle into a
// bounding-box-relative bitmap, one pixel per cycle.
module edge_raster #(
    parameter int unsigned BUF_DIM = gpu_pkg::BUF_DIM
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic [47:0]                  coordinates,
    input  logic                         raster_start,
    output logic                         raster_busy,
    output logic                         raster_done,
    output logic                         raster_error,
    output logic [BUF_DIM*BUF_DIM-1:0]   line_buffer
);

    import gpu_pkg::*;

    localparam int unsigned IDX_W = $clog2(BUF_DIM*BUF_DIM);

    raster_state_t state, state_n;
    logic [47:0] coord_q, src;
    logic [7:0]  xmin_q, ymin_q;
    logic [7:0]  bx_min, bx_max, by_min, by_max;
    logic        oversize;
    logic [1:0]  edge_q, edge_n, sel;
    logic        ld, stp, wr;
    logic [7:0]  xa, ya, xb, yb, px, py, rx, ry;
    logic        last;
    logic [IDX_W-1:0] idx;

    always_comb begin
        bx_min   = min3(coordinates[7:0],  coordinates[23:16], coordinates[39:32]);
        bx_max   = max3(coordinates[7:0],  coordinates[23:16], coordinates[39:32]);
        by_min   = min3(coordinates[15:8], coordinates[31:24], coordinates[47:40]);
        by_max   = max3(coordinates[15:8], coordinates[31:24], coordinates[47:40]);
        oversize = (9'(bx_max - bx_min) > 9'(BUF_DIM - 1)) ||
                   (9'(by_max - by_min) > 9'(BUF_DIM - 1));
    end

    always_comb begin
        state_n = state;
        edge_n  = edge_q;
        sel     = edge_q;
        ld      = 1'b0;
        stp     = 1'b0;
        wr      = 1'b0;
        case (state)
            IDLE:  if (raster_start) state_n = SETUP;
            SETUP: begin
                if (oversize) begin
                    state_n = DONE;
                end else begin
                    state_n = LINE;
                    ld      = 1'b1;
                    sel     = 2'd0;
                    edge_n  = 2'd0;
                end
            end
            LINE: begin
                wr = 1'b1;
                if (last) begin
                    if (edge_q == 2'd2) begin
                        state_n = DONE;
                    end else begin
                        ld     = 1'b1;
                        sel    = edge_q + 2'd1;
                        edge_n = edge_q + 2'd1;
                    end
                end else begin
                    stp = 1'b1;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Edge 0 loads during SETUP, before coord_q has captured the inputs.
    always_comb begin
        src = (state == SETUP) ? coordinates : coord_q;
        case (sel)
            2'd0:    begin xa = src[7:0];   ya = src[15:8];  xb = src[23:16]; yb = src[31:24]; end
            2'd1:    begin xa = src[23:16]; ya = src[31:24]; xb = src[39:32]; yb = src[47:40]; end
            default: begin xa = src[39:32]; ya = src[47:40]; xb = src[7:0];   yb = src[15:8];  end
        endcase
    end

    line_stepper u_stepper (
        .clk   (clk),
        .n_rst (n_rst),
        .load  (ld),
        .step  (stp),
        .xa    (xa),
        .ya    (ya),
        .xb    (xb),
        .yb    (yb),
        .x     (px),
        .y     (py),
        .last  (last)
    );

    always_comb begin
        rx  = px - xmin_q;
        ry  = py - ymin_q;
        idx = IDX_W'(ry) * IDX_W'(BUF_DIM) + IDX_W'(rx);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= IDLE;
            edge_q       <= '0;
            coord_q      <= '0;
            xmin_q       <= '0;
            ymin_q       <= '0;
            raster_error <= 1'b0;
            line_buffer  <= '0;
        end else begin
            state  <= state_n;
            edge_q <= edge_n;
            if (state == SETUP) begin
                coord_q      <= coordinates;
                xmin_q       <= bx_min;
                ymin_q       <= by_min;
                raster_error <= oversize;
                line_buffer  <= '0;
            end
            if (wr) line_buffer[idx] <= 1'b1;
        end
    end

    assign raster_busy = (state != IDLE);
    assign raster_done = (state == DONE);

endmodule

// File: tb/tb_edge_raster.sv
// Directed self-checking bench for edge_raster: reset, triangles, degenerate,
// oversize, boundary size, mid-run reset and start-while-busy.
module tb_edge_raster;

    logic          clk = 1'b0;
    logic          n_rst = 1'b1;
    logic          raster_start = 1'b0;
    logic [47:0]   coordinates = '0;
    logic          raster_busy, raster_done, raster_error;
    logic [4095:0] line_buffer;

    int checks = 0;
    int passed = 0;

    edge_raster #(.BUF_DIM(64)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .coordinates  (coordinates),
        .raster_start (raster_start),
        .raster_busy  (raster_busy),
        .raster_done  (raster_done),
        .raster_error (raster_error),
        .line_buffer  (line_buffer)
    );

    always #5 clk = ~clk;

    function automatic logic [47:0] pack(input logic [7:0] x0, input logic [7:0] y0,
                                         input logic [7:0] x1, input logic [7:0] y1,
                                         input logic [7:0] x2, input logic [7:0] y2);
        return {y2, x2, y1, x1, y0, x0};
    endfunction

    // Expected bitmap of triangle (10,20),(20,20),(10,30) built from its shape.
    function automatic logic [4095:0] tri_exp();
        logic [4095:0] b;
        b = '0;
        for (int k = 0; k <= 10; k++) begin
            b[0*64 + k]        = 1'b1;
            b[k*64 + 0]        = 1'b1;
            b[k*64 + (10 - k)] = 1'b1;
        end
        return b;
    endfunction

    // Starts a raster and returns cycles from the sampling edge to raster_done (-1 on timeout).
    task automatic run(input logic [47:0] c, input int inject_at, input logic [47:0] alt,
                       output int lat);
        @(negedge clk);
        coordinates  = c;
        raster_start = 1'b1;
        @(posedge clk);
        #1 raster_start = 1'b0;
        lat = 1;
        while (1) begin
            @(negedge clk);
            if (raster_done) break;
            if (lat >= 400) begin
                lat = -1;
                break;
            end
            if (lat == inject_at) begin
                raster_start = 1'b1;
                coordinates  = alt;
            end else begin
                raster_start = 1'b0;
                coordinates  = c;
            end
            @(posedge clk);
            lat++;
        end
        raster_start = 1'b0;
    endtask

    task automatic test_reset();
        #2 n_rst = 1'b0;
        #1;
        checks++; if (raster_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", raster_busy); else passed++;
        checks++; if (raster_done !== 1'b0) $display("FAIL reset_done: got %b expected 0", raster_done); else passed++;
        checks++; if (raster_error !== 1'b0) $display("FAIL reset_error: got %b expected 0", raster_error); else passed++;
        checks++; if (line_buffer !== '0) $display("FAIL reset_buffer: %0d bits set, expected 0", $countones(line_buffer)); else passed++;
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_triangle();
        int lat;
        logic [4095:0] e;
        e = tri_exp();
        run(pack(10, 20, 20, 20, 10, 30), 0, '0, lat);
        checks++; if (lat !== 35) $display("FAIL tri_latency: got %0d expected 35", lat); else passed++;
        checks++; if (raster_error !== 1'b0) $display("FAIL tri_error: got %b expected 0", raster_error); else passed++;
        checks++; if (line_buffer !== e) $display("FAIL tri_buffer: %0d bits differ", $countones(line_buffer ^ e)); else passed++;
        @(negedge clk);
        checks++; if ({raster_done, raster_busy} !== 2'b00) $display("FAIL tri_done_pulse: done/busy %b expected 00", {raster_done, raster_busy}); else passed++;
        repeat (5) @(negedge clk);
        checks++; if (line_buffer !== e) $display("FAIL tri_hold: %0d bits differ", $countones(line_buffer ^ e)); else passed++;
    endtask

    task automatic test_point();
        int lat;
        logic [4095:0] e;
        e    = '0;
        e[0] = 1'b1;
        run(pack(5, 5, 5, 5, 5, 5), 0, '0, lat);
        checks++; if (lat !== 5) $display("FAIL point_latency: got %0d expected 5", lat); else passed++;
        checks++; if (raster_error !== 1'b0) $display("FAIL point_error: got %b expected 0", raster_error); else passed++;
        checks++; if (line_buffer !== e) $display("FAIL point_buffer: %0d bits differ", $countones(line_buffer ^ e)); else passed++;
    endtask

    task automatic test_oversize();
        int lat;
        run(pack(0, 0, 100, 0, 0, 10), 0, '0, lat);
        checks++; if (lat !== 2) $display("FAIL over_latency: got %0d expected 2", lat); else passed++;
        checks++; if (raster_error !== 1'b1) $display("FAIL over_error: got %b expected 1", raster_error); else passed++;
        checks++; if (line_buffer !== '0) $display("FAIL over_buffer: %0d bits set, expected 0", $countones(line_buffer)); else passed++;
        repeat (5) @(negedge clk);
        checks++; if (raster_error !== 1'b1) $display("FAIL over_error_hold: got %b expected 1", raster_error); else passed++;
    endtask

    task automatic test_boundary();
        int lat;
        logic [4095:0] e;
        logic [63:0]   row63;
        e = '0;
        for (int k = 0; k < 64; k++) begin
            e[k*64 + k]  = 1'b1;
            e[63*64 + k] = 1'b1;
            e[k*64]      = 1'b1;
        end
        run(pack(0, 0, 63, 63, 0, 63), 0, '0, lat);
        row63 = line_buffer[63*64 +: 64];
        checks++; if (lat !== 194) $display("FAIL bound_latency: got %0d expected 194", lat); else passed++;
        checks++; if (raster_error !== 1'b0) $display("FAIL bound_error: got %b expected 0", raster_error); else passed++;
        checks++; if (row63 !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL bound_row63: got %h expected all ones", row63); else passed++;
        checks++; if (line_buffer !== e) $display("FAIL bound_buffer: %0d bits differ", $countones(line_buffer ^ e)); else passed++;
    endtask

    task automatic test_reset_mid_line();
        int lat;
        logic [4095:0] e;
        e = tri_exp();
        @(negedge clk);
        coordinates  = pack(10, 20, 20, 20, 10, 30);
        raster_start = 1'b1;
        @(posedge clk);
        #1 raster_start = 1'b0;
        repeat (10) @(posedge clk);
        #2 n_rst = 1'b0;
        #1;
        checks++; if (raster_busy !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", raster_busy); else passed++;
        checks++; if (raster_done !== 1'b0) $display("FAIL midrst_done: got %b expected 0", raster_done); else passed++;
        checks++; if (line_buffer !== '0) $display("FAIL midrst_buffer: %0d bits set, expected 0", $countones(line_buffer)); else passed++;
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        run(pack(10, 20, 20, 20, 10, 30), 0, '0, lat);
        checks++; if (lat !== 35) $display("FAIL midrst_latency: got %0d expected 35", lat); else passed++;
        checks++; if (line_buffer !== e) $display("FAIL midrst_buffer_rerun: %0d bits differ", $countones(line_buffer ^ e)); else passed++;
    endtask

    task automatic test_start_while_busy();
        int lat;
        logic [4095:0] e;
        e = tri_exp();
        run(pack(10, 20, 20, 20, 10, 30), 6, pack(0, 0, 100, 0, 0, 10), lat);
        checks++; if (lat !== 35) $display("FAIL busy_latency: got %0d expected 35", lat); else passed++;
        checks++; if (raster_error !== 1'b0) $display("FAIL busy_error: got %b expected 0", raster_error); else passed++;
        checks++; if (line_buffer !== e) $display("FAIL busy_buffer: %0d bits differ", $countones(line_buffer ^ e)); else passed++;
        repeat (3) @(negedge clk);
        checks++; if (raster_busy !== 1'b0) $display("FAIL busy_no_queue: busy %b expected 0", raster_busy); else passed++;
    endtask

    initial begin
        test_reset();
        test_triangle();
        test_point();
        test_oversize();
        test_boundary();
        test_reset_mid_line();
        test_start_while_busy();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
